// File: rtl/pmod_jstk_slave_pkg.sv
// Shared constants, FSM state type and frame-packing helper for the PmodJSTK SPI slave.
// Pure declarations: no latency and no backpressure of its own.
package pmod_jstk_slave_pkg;

  localparam int FRAME_BITS   = 40;
  localparam int CMD_BITS     = 8;
  localparam int CMD_LED_FLAG = 7;
  localparam int POS_W        = 10;
  localparam int BTN_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Byte order on the wire: X low, X high, Y low, Y high, buttons.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [POS_W-1:0] x,
    input logic [POS_W-1:0] y,
    input logic [BTN_W-1:0] b
  );
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
  endfunction

endpackage

// File: rtl/pmod_jstk_slave_if.sv
// SPI mode-0 pin bundle between a joystick master and the emulated device.
// Wires only: no latency and no flow control.
interface pmod_jstk_slave_if;
  logic cs;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output cs, output sclk, output mosi, input miso);
  modport slave  (input cs, input sclk, input mosi, output miso);
endinterface

// File: rtl/pmod_jstk_slave_spi_in_sync.sv
// Multi-flop synchronizer with registered-copy rise/fall pulse detection.
// Pulses appear SYNC_STAGES+1 clk after the pin edge; no backpressure.
module pmod_jstk_slave_spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/pmod_jstk_slave.sv
// PmodJSTK device emulator: oversampled SPI mode-0 slave returning X/Y/buttons and taking the LED command.
// Reacts SYNC_STAGES+2 clk after each pin edge; no backpressure, the SPI master sets the pace.
module pmod_jstk_slave
  import pmod_jstk_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  pmod_jstk_slave_if.slave     spi,
  input  logic [POS_W-1:0]     x_pos,
  input  logic [POS_W-1:0]     y_pos,
  input  logic [BTN_W-1:0]     buttons,
  output logic [1:0]           led,
  output logic                 cmd_valid,
  output logic                 frame_done,
  output logic                 busy
);

  localparam logic [5:0] FRAME_LEN = 6'(FRAME_BYTES * 8);
  localparam logic [5:0] CMD_LEN   = 6'(CMD_BITS);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  pmod_jstk_slave_spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(rst), .din(spi.cs),
    .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  pmod_jstk_slave_spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(spi.sclk),
    .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  pmod_jstk_slave_spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(spi.mosi),
    .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t                  state, state_next;
  logic [FRAME_BITS-1:0]   tx_shift;
  logic [CMD_BITS-1:0]     rx_shift;
  logic [5:0]              bit_cnt;
  logic                    miso_q;

  logic                    snap, do_rx, do_tx, end_frame;
  logic [CMD_BITS-1:0]     rx_next;
  logic [5:0]              cnt_next;

  assign rx_next  = {rx_shift[CMD_BITS-2:0], mosi_s};
  assign cnt_next = bit_cnt + 6'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // cs release takes priority over any coincident sclk edge.
  always_comb begin
    state_next = state;
    snap       = 1'b0;
    do_rx      = 1'b0;
    do_tx      = 1'b0;
    end_frame  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          snap       = 1'b1;
          state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          end_frame  = 1'b1;
          state_next = (bit_cnt == FRAME_LEN) ? ST_DONE : ST_IDLE;
        end else begin
          do_rx = sclk_rise && (bit_cnt < FRAME_LEN);
          do_tx = sclk_fall;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      miso_q    <= 1'b0;
      led       <= 2'b00;
      cmd_valid <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (snap) begin
        tx_shift <= build_frame(x_pos, y_pos, buttons);
        miso_q   <= build_frame(x_pos, y_pos, buttons)[FRAME_BITS-1];
        rx_shift <= '0;
        bit_cnt  <= '0;
      end
      if (end_frame) miso_q <= 1'b0;
      if (do_rx) begin
        rx_shift <= rx_next;
        bit_cnt  <= cnt_next;
        if (cnt_next == CMD_LEN) begin
          cmd_valid <= 1'b1;
          if (rx_next[CMD_LED_FLAG]) led <= rx_next[1:0];
        end
      end
      // Zeros shift in behind the payload, so miso idles low past the last bit.
      if (do_tx) begin
        tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
        miso_q   <= tx_shift[FRAME_BITS-2];
      end
    end
  end

  assign spi.miso   = miso_q;
  assign busy       = (state == ST_ACTIVE);
  assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_pmod_jstk_slave.sv
// Scoreboard bench for pmod_jstk_slave: expected miso bytes are queued per frame and popped as the
// bench-side SPI master completes each byte.
module tb_pmod_jstk_slave;
  import pmod_jstk_slave_pkg::*;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  x_pos = '0;
  logic [9:0]  y_pos = '0;
  logic [2:0]  buttons = '0;
  logic [1:0]  led;
  logic        cmd_valid, frame_done, busy;

  int          vec = 0;
  int          err = 0;
  int          cmd_cnt = 0;
  int          done_cnt = 0;
  logic [7:0]  exp_q[$];

  pmod_jstk_slave_if spi ();

  pmod_jstk_slave #(.SYNC_STAGES(2), .FRAME_BYTES(5)) dut (
    .clk(clk), .rst(rst), .spi(spi),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
    .led(led), .cmd_valid(cmd_valid), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid)  cmd_cnt++;
    if (frame_done) done_cnt++;
  end

  task automatic push5(input logic [7:0] b0, b1, b2, b3, b4);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    exp_q.push_back(b3); exp_q.push_back(b4);
  endtask

  // One SPI mode-0 frame; chg_bit/rst_bit < 0 disable the mid-frame x change / reset pulse.
  task automatic xfer(input int nbits, input logic [47:0] mosi_bits,
                      input int chg_bit, input logic [9:0] chg_x, input int rst_bit);
    logic [7:0] rxb;
    logic [7:0] expb;
    rxb = '0;
    @(negedge clk); spi.cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_pos = chg_x;
      if (i == rst_bit) begin
        rst = 1'b1; @(negedge clk); rst = 1'b0;
      end
      spi.mosi = mosi_bits[47-i];
      repeat (HALF) @(negedge clk);
      rxb = {rxb[6:0], spi.miso};
      spi.sclk = 1'b1;
      if ((i % 8) == 7 && exp_q.size() > 0) begin
        expb = exp_q.pop_front();
        vec++;
        if (rxb !== expb) begin
          $display("FAIL miso_byte%0d got %h want %h", i / 8, rxb, expb);
          err++;
        end
      end
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi.cs = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec++; if (spi.miso !== 1'b0)   begin $display("FAIL reset_miso got %b want 0", spi.miso); err++; end
    vec++; if (led !== 2'b00)       begin $display("FAIL reset_led got %b want 00", led); err++; end
    vec++; if (cmd_valid !== 1'b0)  begin $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); err++; end
    vec++; if (frame_done !== 1'b0) begin $display("FAIL reset_frame_done got %b want 0", frame_done); err++; end
    vec++; if (busy !== 1'b0)       begin $display("FAIL reset_busy got %b want 0", busy); err++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_full_frame();
    int c0, d0;
    c0 = cmd_cnt; d0 = done_cnt;
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    push5(8'hA5, 8'h02, 8'h3C, 8'h01, 8'h05);
    xfer(40, 48'h83_00_00_00_00_00, -1, '0, -1);
    vec++; if (led !== 2'b11) begin $display("FAIL full_led got %b want 11", led); err++; end
    vec++; if (cmd_cnt - c0 != 1) begin $display("FAIL full_cmd_pulses got %0d want 1", cmd_cnt - c0); err++; end
    vec++; if (done_cnt - d0 != 1) begin $display("FAIL full_done_pulses got %0d want 1", done_cnt - d0); err++; end
    vec++; if (busy !== 1'b0) begin $display("FAIL full_busy_after got %b want 0", busy); err++; end
  endtask

  task automatic test_cmd_no_flag();
    int c0, d0;
    c0 = cmd_cnt; d0 = done_cnt;
    push5(8'hA5, 8'h02, 8'h3C, 8'h01, 8'h05);
    xfer(40, 48'h02_00_00_00_00_00, -1, '0, -1);
    vec++; if (led !== 2'b11) begin $display("FAIL noflag_led got %b want 11", led); err++; end
    vec++; if (cmd_cnt - c0 != 1) begin $display("FAIL noflag_cmd_pulses got %0d want 1", cmd_cnt - c0); err++; end
    vec++; if (done_cnt - d0 != 1) begin $display("FAIL noflag_done_pulses got %0d want 1", done_cnt - d0); err++; end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    exp_q.push_back(8'hA5);
    xfer(12, 48'h83_00_00_00_00_00, -1, '0, -1);
    vec++; if (done_cnt != d0) begin $display("FAIL abort_done_pulses got %0d want 0", done_cnt - d0); err++; end
    vec++; if (busy !== 1'b0) begin $display("FAIL abort_busy got %b want 0", busy); err++; end
    vec++; if (spi.miso !== 1'b0) begin $display("FAIL abort_miso got %b want 0", spi.miso); err++; end
    x_pos = 10'h155; y_pos = 10'h2AA; buttons = 3'b010;
    push5(8'h55, 8'h01, 8'hAA, 8'h02, 8'h02);
    xfer(40, 48'h81_00_00_00_00_00, -1, '0, -1);
    vec++; if (led !== 2'b01) begin $display("FAIL abort_next_led got %b want 01", led); err++; end
    vec++; if (done_cnt - d0 != 1) begin $display("FAIL abort_next_done got %0d want 1", done_cnt - d0); err++; end
  endtask

  task automatic test_mid_change();
    x_pos = 10'h000; y_pos = 10'h13C; buttons = 3'b000;
    push5(8'h00, 8'h00, 8'h3C, 8'h01, 8'h00);
    xfer(40, 48'h00_00_00_00_00_00, 4, 10'h3FF, -1);
    push5(8'hFF, 8'h03, 8'h3C, 8'h01, 8'h00);
    xfer(40, 48'h00_00_00_00_00_00, -1, '0, -1);
    vec++; if (led !== 2'b01) begin $display("FAIL midchg_led_held got %b want 01", led); err++; end
  endtask

  task automatic test_long_frame();
    int c0, d0;
    c0 = cmd_cnt; d0 = done_cnt;
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    push5(8'hA5, 8'h02, 8'h3C, 8'h01, 8'h05);
    exp_q.push_back(8'h00);
    xfer(48, 48'h82_00_00_00_00_00, -1, '0, -1);
    vec++; if (done_cnt - d0 != 1) begin $display("FAIL long_done_pulses got %0d want 1", done_cnt - d0); err++; end
    vec++; if (cmd_cnt - c0 != 1) begin $display("FAIL long_cmd_pulses got %0d want 1", cmd_cnt - c0); err++; end
    vec++; if (led !== 2'b10) begin $display("FAIL long_led got %b want 10", led); err++; end
  endtask

  task automatic test_reset_mid();
    int c0, d0;
    c0 = cmd_cnt; d0 = done_cnt;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h02);
    xfer(40, 48'h83_00_00_00_00_00, -1, '0, 20);
    vec++; if (led !== 2'b00) begin $display("FAIL rstmid_led got %b want 00", led); err++; end
    vec++; if (busy !== 1'b0) begin $display("FAIL rstmid_busy got %b want 0", busy); err++; end
    vec++; if (done_cnt != d0) begin $display("FAIL rstmid_done_pulses got %0d want 0", done_cnt - d0); err++; end
    vec++; if (cmd_cnt - c0 != 1) begin $display("FAIL rstmid_cmd_pulses got %0d want 1", cmd_cnt - c0); err++; end
  endtask

  task automatic test_idle_sclk();
    int c0, d0;
    c0 = cmd_cnt; d0 = done_cnt;
    spi.cs = 1'b1; spi.mosi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      repeat (HALF) @(negedge clk); spi.sclk = 1'b1;
      vec++; if (busy !== 1'b0) begin $display("FAIL idle_busy cycle%0d got %b want 0", i, busy); err++; end
      repeat (HALF) @(negedge clk); spi.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi.mosi = 1'b0;
    vec++; if (spi.miso !== 1'b0) begin $display("FAIL idle_miso got %b want 0", spi.miso); err++; end
    vec++; if (cmd_cnt != c0 || done_cnt != d0) begin
      $display("FAIL idle_pulses got cmd %0d done %0d want 0 0", cmd_cnt - c0, done_cnt - d0); err++;
    end
    vec++; if (led !== 2'b00) begin $display("FAIL idle_led got %b want 00", led); err++; end
  endtask

  initial begin
    spi.cs = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0;
    test_reset();
    test_full_frame();
    test_cmd_no_flag();
    test_abort();
    test_mid_change();
    test_long_frame();
    test_reset_mid();
    test_idle_sclk();
    vec++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
